// File: rtl/ram2_rd_arbiter.sv
// Three-requester round-robin read arbiter for ram2 port A.
// Lock support plus a fixed-latency return path with in-order rvalid.
module ram2_rd_arbiter #(
  parameter int ADDR_WIDTH_RAM2 = 16,
  parameter int READ_DELAY      = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   req,
  input  logic [3*ADDR_WIDTH_RAM2-1:0] req_addr,
  input  logic [2:0]                   lock,
  output logic [2:0]                   gnt,
  output logic [2:0]                   rvalid,
  output logic                         rdata,
  output logic [ADDR_WIDTH_RAM2-1:0]   addr_ram2_A,
  input  logic                         dout_ram2_A,
  output logic                         busy
);

  logic [1:0]            last_owner;
  logic [2:0]            elig;
  logic                  locked;
  logic                  win_vld;
  logic [1:0]            win;
  logic [1:0]            o0, o1, o2;
  logic [READ_DELAY-1:0] dl_vld;
  logic [1:0]            dl_own [READ_DELAY];

  assign elig   = req & ~gnt;
  assign locked = lock[last_owner] & req[last_owner];
  assign rdata  = dout_ram2_A;
  assign busy   = |dl_vld;

  always_comb begin
    o0 = 2'd0;
    o1 = 2'd1;
    o2 = 2'd2;
    case (last_owner)
      2'd0: begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd1: begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: ;
    endcase
  end

  // A locked owner in its own gnt cycle idles the bus instead of yielding.
  always_comb begin
    win_vld = 1'b0;
    win     = last_owner;
    if (locked) begin
      win_vld = ~gnt[last_owner];
    end else if (elig[o0]) begin
      win_vld = 1'b1;
      win     = o0;
    end else if (elig[o1]) begin
      win_vld = 1'b1;
      win     = o1;
    end else if (elig[o2]) begin
      win_vld = 1'b1;
      win     = o2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt         <= 3'b000;
      rvalid      <= 3'b000;
      addr_ram2_A <= '0;
      last_owner  <= 2'd2;
      dl_vld      <= '0;
      for (int i = 0; i < READ_DELAY; i++)
        dl_own[i] <= 2'd0;
    end else begin
      gnt <= win_vld ? (3'b001 << win) : 3'b000;
      if (win_vld) begin
        addr_ram2_A <= req_addr[win*ADDR_WIDTH_RAM2 +: ADDR_WIDTH_RAM2];
        last_owner  <= win;
      end
      dl_vld[0] <= win_vld;
      dl_own[0] <= win;
      for (int i = 1; i < READ_DELAY; i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_own[i] <= dl_own[i-1];
      end
      rvalid <= dl_vld[READ_DELAY-1]
              ? (3'b001 << dl_own[READ_DELAY-1]) : 3'b000;
    end
  end

endmodule

// File: tb/tb_ram2_rd_arbiter.sv
// Directed bench for ram2_rd_arbiter at READ_DELAY 5 and 1.
// ram2 is modelled as content = addr[0] behind an address delay line.
module tb_ram2_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req1, lock1, gnt1, rvalid1;
  logic [47:0] addr1;
  logic [15:0] addr_a1;
  logic        rdata1, dout1, busy1;
  logic [2:0]  req2, lock2, gnt2, rvalid2;
  logic [47:0] addr2;
  logic [15:0] addr_a2;
  logic        rdata2, dout2, busy2;
  logic [15:0] hist1 [16];
  logic [15:0] hist2 [16];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  ram2_rd_arbiter #(.ADDR_WIDTH_RAM2(16), .READ_DELAY(5)) u_d5 (
    .clk(clk), .rst(rst), .req(req1), .req_addr(addr1), .lock(lock1),
    .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1),
    .addr_ram2_A(addr_a1), .dout_ram2_A(dout1), .busy(busy1));

  ram2_rd_arbiter #(.ADDR_WIDTH_RAM2(16), .READ_DELAY(1)) u_d1 (
    .clk(clk), .rst(rst), .req(req2), .req_addr(addr2), .lock(lock2),
    .gnt(gnt2), .rvalid(rvalid2), .rdata(rdata2),
    .addr_ram2_A(addr_a2), .dout_ram2_A(dout2), .busy(busy2));

  always @(posedge clk) begin
    for (int i = 15; i > 0; i--) begin
      hist1[i] <= hist1[i-1];
      hist2[i] <= hist2[i-1];
    end
    hist1[0] <= addr_a1;
    hist2[0] <= addr_a2;
  end

  assign dout1 = hist1[4][0];
  assign dout2 = hist2[0][0];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    req1 = 3'b000; lock1 = 3'b000; addr1 = '0;
    req2 = 3'b000; lock2 = 3'b000; addr2 = '0;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req1 = 3'b111; addr1 = {16'h1111, 16'h2222, 16'h3333};
    req2 = 3'b111; addr2 = {16'h1111, 16'h2222, 16'h3333};
    lock1 = 3'b000; lock2 = 3'b000;
    step;
    step;
    total++;
    if (gnt1 !== 3'b000) begin bad++; $display("FAIL rst_gnt: got %b want 000", gnt1); end
    total++;
    if (rvalid1 !== 3'b000) begin bad++; $display("FAIL rst_rvalid: got %b want 000", rvalid1); end
    total++;
    if (addr_a1 !== 16'h0) begin bad++; $display("FAIL rst_addr: got %h want 0000", addr_a1); end
    total++;
    if (busy1 !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy1); end
    total++;
    if (gnt2 !== 3'b000 || busy2 !== 1'b0) begin
      bad++; $display("FAIL rst_d1: got gnt=%b busy=%b want 000/0", gnt2, busy2);
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    apply_reset;
    addr1 = {16'h0, 16'h0, 16'h0123};
    req1 = 3'b001;
    step;
    total++;
    if (gnt1 !== 3'b001) begin bad++; $display("FAIL single_gnt: got %b want 001", gnt1); end
    total++;
    if (addr_a1 !== 16'h0123) begin bad++; $display("FAIL single_addr: got %h want 0123", addr_a1); end
    total++;
    if (busy1 !== 1'b1) begin bad++; $display("FAIL single_busy_g: got %b want 1", busy1); end
    req1 = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      step;
      total++;
      if (busy1 !== 1'b1 || rvalid1 !== 3'b000 || gnt1 !== 3'b000) begin
        bad++;
        $display("FAIL single_wait%0d: got busy=%b rvalid=%b gnt=%b want 1/000/000",
                 k, busy1, rvalid1, gnt1);
      end
    end
    step;
    total++;
    if (rvalid1 !== 3'b001) begin bad++; $display("FAIL single_rvalid: got %b want 001", rvalid1); end
    total++;
    if (rdata1 !== 1'b1) begin bad++; $display("FAIL single_rdata: got %b want 1", rdata1); end
    total++;
    if (busy1 !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy1); end
  endtask

  task automatic test_round_robin;
    logic [2:0] eg, ev;
    logic       ed;
    apply_reset;
    addr1 = {16'h0789, 16'h0456, 16'h0123};
    req1 = 3'b111;
    for (int c = 1; c <= 12; c++) begin
      step;
      eg = (c <= 6) ? (3'b001 << ((c - 1) % 3)) : 3'b000;
      ev = (c >= 6 && c <= 11) ? (3'b001 << ((c - 6) % 3)) : 3'b000;
      ed = (ev == 3'b010) ? 1'b0 : 1'b1;
      total++;
      if (gnt1 !== eg) begin bad++; $display("FAIL rr_gnt c%0d: got %b want %b", c, gnt1, eg); end
      total++;
      if (rvalid1 !== ev) begin bad++; $display("FAIL rr_rvalid c%0d: got %b want %b", c, rvalid1, ev); end
      if (ev != 3'b000) begin
        total++;
        if (rdata1 !== ed) begin bad++; $display("FAIL rr_rdata c%0d: got %b want %b", c, rdata1, ed); end
      end
      if (c == 6) req1 = 3'b000;
    end
  endtask

  task automatic test_lock;
    logic [2:0] eg;
    apply_reset;
    addr1 = {16'h0BBB, 16'h0, 16'h0AAA};
    lock1 = 3'b001;
    req1 = 3'b101;
    for (int c = 1; c <= 8; c++) begin
      step;
      eg = (c % 2 == 1) ? 3'b001 : 3'b000;
      total++;
      if (gnt1 !== eg) begin bad++; $display("FAIL lock_gnt c%0d: got %b want %b", c, gnt1, eg); end
      total++;
      if (addr_a1 !== 16'h0AAA) begin bad++; $display("FAIL lock_addr c%0d: got %h want 0aaa", c, addr_a1); end
    end
    lock1 = 3'b000;
    step;
    total++;
    if (gnt1 !== 3'b100) begin bad++; $display("FAIL unlock_gnt: got %b want 100", gnt1); end
    total++;
    if (addr_a1 !== 16'h0BBB) begin bad++; $display("FAIL unlock_addr: got %h want 0bbb", addr_a1); end
    req1 = 3'b000;
  endtask

  task automatic test_reset_mid;
    apply_reset;
    addr1 = {16'h0003, 16'h0005, 16'h0007};
    req1 = 3'b111;
    for (int c = 1; c <= 3; c++) begin
      step;
      total++;
      if (gnt1 !== (3'b001 << (c - 1))) begin
        bad++; $display("FAIL mid_gnt c%0d: got %b want %b", c, gnt1, 3'b001 << (c - 1));
      end
    end
    rst = 1'b1;
    req1 = 3'b000;
    #1;
    total++;
    if (busy1 !== 1'b0 || gnt1 !== 3'b000) begin
      bad++; $display("FAIL mid_async: got busy=%b gnt=%b want 0/000", busy1, gnt1);
    end
    step;
    total++;
    if (addr_a1 !== 16'h0 || rvalid1 !== 3'b000) begin
      bad++; $display("FAIL mid_inrst: got addr=%h rvalid=%b want 0000/000", addr_a1, rvalid1);
    end
    rst = 1'b0;
    req1 = 3'b010;
    step;
    total++;
    if (gnt1 !== 3'b010) begin bad++; $display("FAIL mid_first: got %b want 010", gnt1); end
    req1 = 3'b000;
    for (int c = 6; c <= 9; c++) begin
      step;
      total++;
      if (rvalid1 !== 3'b000) begin bad++; $display("FAIL mid_ghost c%0d: got %b want 000", c, rvalid1); end
    end
    step;
    total++;
    if (rvalid1 !== 3'b010) begin bad++; $display("FAIL mid_rvalid: got %b want 010", rvalid1); end
  endtask

  task automatic test_delay1;
    logic [2:0] eg, ev;
    logic       ed;
    apply_reset;
    addr2 = {16'h0, 16'h0002, 16'h0001};
    req2 = 3'b011;
    for (int c = 1; c <= 6; c++) begin
      step;
      eg = (c <= 4) ? ((c % 2 == 1) ? 3'b001 : 3'b010) : 3'b000;
      ev = (c >= 2 && c <= 5) ? (((c - 1) % 2 == 1) ? 3'b001 : 3'b010) : 3'b000;
      ed = (ev == 3'b001);
      total++;
      if (gnt2 !== eg) begin bad++; $display("FAIL d1_gnt c%0d: got %b want %b", c, gnt2, eg); end
      total++;
      if (rvalid2 !== ev) begin bad++; $display("FAIL d1_rvalid c%0d: got %b want %b", c, rvalid2, ev); end
      total++;
      if (busy2 !== (eg != 3'b000)) begin
        bad++; $display("FAIL d1_busy c%0d: got %b want %b", c, busy2, eg != 3'b000);
      end
      if (ev != 3'b000) begin
        total++;
        if (rdata2 !== ed) begin bad++; $display("FAIL d1_rdata c%0d: got %b want %b", c, rdata2, ed); end
      end
      if (c == 4) req2 = 3'b000;
    end
  endtask

  task automatic test_cancel;
    apply_reset;
    addr1 = {16'h0, 16'h0777, 16'h0100};
    lock1 = 3'b001;
    req1 = 3'b001;
    for (int c = 1; c <= 14; c++) begin
      step;
      total++;
      if (gnt1[1] !== 1'b0) begin bad++; $display("FAIL cancel_gnt c%0d: got %b want x0x", c, gnt1); end
      total++;
      if (rvalid1[1] !== 1'b0) begin bad++; $display("FAIL cancel_rvalid c%0d: got %b want x0x", c, rvalid1); end
      if (c == 2) req1 = 3'b011;
      if (c == 5) req1 = 3'b001;
      if (c == 8) lock1 = 3'b000;
      if (c == 12) req1 = 3'b000;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_lock;
    test_reset_mid;
    test_delay1;
    test_cancel;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
